// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BHT/BTB with 2-bit saturating counters,
// one-cycle lookup response, execute-driven training and a registered mispredict pulse.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        lk_rsp_valid,
  output logic        lk_rsp_taken,
  output logic [31:0] lk_rsp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        flush,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  // Table storage
  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [1:0]          ctr_r    [ENTRIES];

  // Registered outputs
  logic        rsp_valid_r;
  logic        rsp_taken_r;
  logic [31:0] rsp_target_r;
  logic        mispredict_r;
  logic [31:0] redirect_r;
  logic [15:0] cnt_r;

  // Lookup-side decode
  logic [IDX_BITS-1:0] lk_idx_s;
  logic [TAG_BITS-1:0] lk_tag_s;
  logic                lk_hit_s;
  logic                lk_taken_s;
  logic [31:0]         lk_target_s;

  // Update-side decode
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;
  logic                mispred_s;
  logic [31:0]         redirect_s;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    case ({taken, c})
      3'b1_00: n = 2'b01;
      3'b1_01: n = 2'b10;
      3'b1_10: n = 2'b11;
      3'b1_11: n = 2'b11;
      3'b0_00: n = 2'b00;
      3'b0_01: n = 2'b00;
      3'b0_10: n = 2'b01;
      3'b0_11: n = 2'b10;
      default: n = 2'b01;
    endcase
    return n;
  endfunction

  assign lk_idx_s  = lk_pc[IDX_BITS+1:2];
  assign lk_tag_s  = lk_pc[TAG_HI:TAG_LO];
  assign upd_idx_s = upd_pc[IDX_BITS+1:2];
  assign upd_tag_s = upd_pc[TAG_HI:TAG_LO];

  // Lookup: reads pre-update contents, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit_s    = 1'b0;
    lk_taken_s  = 1'b0;
    lk_target_s = lk_pc + 32'd4;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      lk_hit_s = 1'b1;
    end else begin
      lk_hit_s = 1'b0;
    end
    if (lk_hit_s && ctr_r[lk_idx_s][1]) begin
      lk_taken_s  = 1'b1;
      lk_target_s = target_r[lk_idx_s];
    end else begin
      lk_taken_s  = 1'b0;
      lk_target_s = lk_pc + 32'd4;
    end
  end

  // Update hit detection and mispredict evaluation.
  always_comb begin
    upd_hit_s  = 1'b0;
    mispred_s  = 1'b0;
    redirect_s = upd_pc + 32'd4;
    if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
      upd_hit_s = 1'b1;
    end else begin
      upd_hit_s = 1'b0;
    end
    if (upd_valid && ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)))) begin
      mispred_s = 1'b1;
    end else begin
      mispred_s = 1'b0;
    end
    if (upd_taken) begin
      redirect_s = upd_target;
    end else begin
      redirect_s = upd_pc + 32'd4;
    end
  end

  // Table training; flush wins over a same-cycle update and only clears valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= ctr_step(ctr_r[upd_idx_s], upd_taken);
        if (upd_taken) begin
          target_r[upd_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target;
        ctr_r[upd_idx_s]    <= 2'b10;
      end
    end
  end

  // Lookup response register; payload holds while no lookup is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_taken_r  <= 1'b0;
      rsp_target_r <= 32'd0;
    end else begin
      rsp_valid_r <= lk_valid;
      if (lk_valid) begin
        rsp_taken_r  <= lk_taken_s;
        rsp_target_r <= lk_target_s;
      end
    end
  end

  // Mispredict pulse, held redirect target and saturating event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_r <= 1'b0;
      redirect_r   <= 32'd0;
      cnt_r        <= 16'd0;
    end else begin
      mispredict_r <= mispred_s;
      if (mispred_s) begin
        redirect_r <= redirect_s;
        if (cnt_r != 16'hFFFF) begin
          cnt_r <= cnt_r + 16'd1;
        end
      end
    end
  end

  assign lk_rsp_valid  = rsp_valid_r;
  assign lk_rsp_taken  = rsp_taken_r;
  assign lk_rsp_target = rsp_target_r;
  assign mispredict    = mispredict_r;
  assign redirect_pc   = redirect_r;
  assign mispred_cnt   = cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor: per-cycle vectors with expected responses
// queued on issue and checked on return, plus reset and counter-saturation sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_rsp_valid;
  logic        lk_rsp_taken;
  logic [31:0] lk_rsp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_cnt;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_taken(lk_rsp_taken), .lk_rsp_target(lk_rsp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispredict(mispredict), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk_v;
    logic [31:0] lk_pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        fl;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_misp;
    logic [31:0] e_redir;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] tgt;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int tests = 0;
  int failed = 0;
  logic        held_taken;
  logic [31:0] held_tgt;
  logic [31:0] held_redir;

  function automatic vec_t mk(logic lk_v, logic [31:0] lpc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                              logic fl, logic e_taken, logic [31:0] e_tgt, logic e_misp,
                              logic [31:0] e_redir, logic [15:0] e_cnt);
    vec_t v;
    v.lk_v = lk_v; v.lk_pc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.fl = fl; v.e_taken = e_taken; v.e_tgt = e_tgt;
    v.e_misp = e_misp; v.e_redir = e_redir; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    lk_valid = 1'b0; lk_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int row);
    rsp_t r;
    lk_valid = v.lk_v; lk_pc = v.lk_pc; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
    upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_target = v.uptgt; flush = v.fl;
    if (v.lk_v) begin
      r.taken = v.e_taken; r.tgt = v.e_tgt;
      sb.push_back(r);
    end
    if (v.e_misp) held_redir = v.e_redir;
    @(posedge clk);
    #1;
    chk($sformatf("row%0d rsp_valid", row), {31'd0, lk_rsp_valid}, {31'd0, v.lk_v});
    if (lk_rsp_valid) begin
      if (sb.size() == 0) begin
        chk($sformatf("row%0d unexpected rsp", row), 32'd1, 32'd0);
      end else begin
        r = sb.pop_front();
        held_taken = r.taken; held_tgt = r.tgt;
      end
    end
    chk($sformatf("row%0d rsp_taken", row), {31'd0, lk_rsp_taken}, {31'd0, held_taken});
    chk($sformatf("row%0d rsp_target", row), lk_rsp_target, held_tgt);
    chk($sformatf("row%0d mispredict", row), {31'd0, mispredict}, {31'd0, v.e_misp});
    chk($sformatf("row%0d redirect_pc", row), redirect_pc, held_redir);
    chk($sformatf("row%0d mispred_cnt", row), {16'd0, mispred_cnt}, {16'd0, v.e_cnt});
    drive_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    held_taken = 1'b0; held_tgt = 32'd0; held_redir = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'd0, lk_rsp_valid}, 32'd0);
    chk("reset rsp_target", lk_rsp_target, 32'd0);
    chk("reset mispredict", {31'd0, mispredict}, 32'd0);
    chk("reset redirect", redirect_pc, 32'd0);
    chk("reset cnt", {16'd0, mispred_cnt}, 32'd0);
    rst_n = 1'b1;

    //             lk  lk_pc        uv  upc          ut  utgt         upt uptgt        fl  eT  eTgt         eM  eRedir       eCnt
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h104,  0, 32'h0,    16'd0));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  1, 32'h80,   0, 32'h104,  0, 0, 32'h0,    1, 32'h80,   16'd1));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h80,   0, 32'h0,    16'd1));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  1, 32'h80,   1, 32'h80,   0, 0, 32'h0,    0, 32'h0,    16'd1));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  1, 32'h80,   1, 32'h80,   0, 0, 32'h0,    0, 32'h0,    16'd1));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  1, 32'h80,   1, 32'h80,   0, 0, 32'h0,    0, 32'h0,    16'd1));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  0, 32'h0,    1, 32'h80,   0, 0, 32'h0,    1, 32'h104,  16'd2));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h80,   0, 32'h0,    16'd2));
    vecs.push_back(mk(1, 32'h100,  1, 32'h100,  0, 32'h0,    1, 32'h80,   0, 1, 32'h80,   1, 32'h104,  16'd3));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h104,  0, 32'h0,    16'd3));
    vecs.push_back(mk(0, 32'h0,    1, 32'h100,  1, 32'h90,   1, 32'h80,   0, 0, 32'h0,    1, 32'h90,   16'd4));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h90,   0, 32'h0,    16'd4));
    vecs.push_back(mk(1, 32'h200,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h204,  0, 32'h0,    16'd4));
    vecs.push_back(mk(0, 32'h0,    1, 32'h200,  1, 32'h400,  0, 32'h204,  0, 0, 32'h0,    1, 32'h400,  16'd5));
    vecs.push_back(mk(1, 32'h200,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h400,  0, 32'h0,    16'd5));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h104,  0, 32'h0,    16'd5));
    vecs.push_back(mk(0, 32'h0,    1, 32'h500,  0, 32'h0,    0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    16'd5));
    vecs.push_back(mk(1, 32'h200,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h400,  0, 32'h0,    16'd5));
    vecs.push_back(mk(1, 32'h300,  1, 32'h300,  1, 32'h700,  0, 32'h304,  0, 0, 32'h304,  1, 32'h700,  16'd6));
    vecs.push_back(mk(1, 32'h300,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h700,  0, 32'h0,    16'd6));
    vecs.push_back(mk(0, 32'h0,    1, 32'h1004, 1, 32'h2000, 1, 32'h2000, 0, 0, 32'h0,    0, 32'h0,    16'd6));
    vecs.push_back(mk(1, 32'h1004, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h2000, 0, 32'h0,    16'd6));
    vecs.push_back(mk(1, 32'h300,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 1, 32'h700,  0, 32'h0,    16'd6));
    vecs.push_back(mk(0, 32'h0,    1, 32'h1004, 1, 32'h3000, 1, 32'h3000, 1, 0, 32'h0,    0, 32'h0,    16'd6));
    vecs.push_back(mk(0, 32'h0,    1, 32'h300,  0, 32'h0,    1, 32'h700,  1, 0, 32'h0,    1, 32'h304,  16'd7));
    vecs.push_back(mk(1, 32'h1004, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h1008, 0, 32'h0,    16'd7));
    vecs.push_back(mk(1, 32'h300,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h304,  0, 32'h0,    16'd7));
    vecs.push_back(mk(1, 32'h100,  0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 32'h104,  0, 32'h0,    16'd7));
    vecs.push_back(mk(1, 32'h300,  1, 32'h300,  1, 32'h700,  0, 32'h304,  0, 0, 32'h304,  1, 32'h700,  16'd8));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-lookup with a mispredicting update in flight.
    lk_valid = 1'b1; lk_pc = 32'h300;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b0; upd_pred_taken = 1'b1;
    upd_pred_target = 32'h700;
    @(posedge clk);
    #1;
    chk("pre-reset rsp_valid", {31'd0, lk_rsp_valid}, 32'd1);
    chk("pre-reset mispredict", {31'd0, mispredict}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", {31'd0, lk_rsp_valid}, 32'd0);
    chk("midreset rsp_taken", {31'd0, lk_rsp_taken}, 32'd0);
    chk("midreset rsp_target", lk_rsp_target, 32'd0);
    chk("midreset mispredict", {31'd0, mispredict}, 32'd0);
    chk("midreset redirect", redirect_pc, 32'd0);
    chk("midreset cnt", {16'd0, mispred_cnt}, 32'd0);
    drive_idle();
    sb.delete();
    held_taken = 1'b0; held_tgt = 32'd0; held_redir = 32'd0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 32'h200, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h204, 0, 32'h0, 16'd0), 100);

    // Counter saturation: 65535 mispredicts reach FFFF and then hold.
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h10;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt near sat", {16'd0, mispred_cnt}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("cnt at sat", {16'd0, mispred_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt holds sat", {16'd0, mispred_cnt}, 32'h0000FFFF);
    chk("sat mispredict", {31'd0, mispredict}, 32'd1);
    chk("sat redirect", redirect_pc, 32'h10);
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
